// File: rtl/pcie_cfg_access_arbiter.sv
// Round-robin arbiter sharing the host cfg-space access port among NUM_REQ requesters.
// Define CFG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module pcie_cfg_access_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 cfg_req,
  output logic                 cfg_write,
  output logic [31:0]          cfg_addr,
  output logic [31:0]          cfg_wdata,
  input  logic                 cfg_ack,
  input  logic [31:0]          cfg_rdata,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [IW-1:0] r_gnt;
  logic [IW-1:0] w_gnt;
  logic          w_any;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          w_tmo;

`ifdef CFG_ARB_FIXED_PRIO_EN
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_any = 1'b1;
        w_gnt = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_j;

  // Search upward from r_ptr+1, wrapping at NUM_REQ-1.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_j   = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (w_j == IW'(NUM_REQ - 1)) ? '0 : w_j + IW'(1);
      if (!w_any && req_valid[w_j]) begin
        w_any = 1'b1;
        w_gnt = w_j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IW'(NUM_REQ - 1);
    end else if (r_state == S_IDLE && w_any) begin
      r_ptr <= w_gnt;
    end
  end
`endif

  assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_nstate  = r_state;
    req_ready = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready = NUM_REQ'(1) << w_gnt;
          w_nstate  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cfg_ack || w_tmo) w_nstate = S_RESP;
      end
      S_RESP:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_write <= req_write[w_gnt];
            r_addr  <= req_addr[32*w_gnt +: 32];
            r_wdata <= req_wdata[32*w_gnt +: 32];
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // Ack on the last allowed cycle still wins over the timeout.
          if (cfg_ack) begin
            r_rdata <= r_write ? '0 : cfg_rdata;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= '1;
            r_err   <= 1'b1;
          end
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign cfg_req   = (r_state == S_WAIT);
  assign cfg_write = r_write;
  assign cfg_addr  = r_addr;
  assign cfg_wdata = r_wdata;
  assign rsp_valid = (r_state == S_RESP) ? (NUM_REQ'(1) << r_gnt) : '0;
  assign rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
  assign rsp_err   = (r_state == S_RESP) ? r_err : 1'b0;

endmodule
